// File: rtl/pip_game_pkg.sv
// Shared types and defaults for the point-in-polygon game judging path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: judge FSM state encoding, the aligned-pixel bundle carried
// through the delay line, default frame geometry and verdict thresholds.
package pip_game_pkg;

   localparam int COORD_W    = 10;
   localparam int H_ACTIVE_C = 640;
   localparam int V_ACTIVE_C = 480;
   localparam int IN_MIN_C   = 20000;
   localparam int OUT_MAX_C  = 500;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_SOF = 2'd1,
      ACCUM    = 2'd2,
      DECIDE   = 2'd3
   } judge_state_t;

   // One pixel's worth of timing and mask information.
   typedef struct packed {
      logic               de;
      logic               fg;
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
   } pix_t;

endpackage

// File: rtl/pixel_align_delay.sv
// Delays the pixel bundle {DE, fg, x, y} so it lines up with in_polygon.
// Latency: exactly DEPTH clk cycles.
// Backpressure: none; free-running shift register, one pixel per clock.
//
// Ports:
//   clk, reset : pixel clock, synchronous active-high reset (clears every stage)
//   pix_in     : undelayed pixel bundle
//   pix_out    : pixel bundle DEPTH cycles later
module pixel_align_delay
   import pip_game_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic clk,
   input  logic reset,
   input  pix_t pix_in,
   output pix_t pix_out
);

   pix_t stage [DEPTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage[i] <= '0;
         end
      end else begin
         stage[0] <= pix_in;
         for (int i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign pix_out = stage[DEPTH-1];

endmodule

// File: rtl/polygon_fit_judge.sv
// Counts silhouette pixels inside/outside the wall polygon over one frame and issues a pass/fail verdict.
// Latency: judge_done one cycle after the last aligned pixel (H_ACTIVE-1, V_ACTIVE-1) is counted.
// Backpressure: none; judge_start is ignored while busy, polygon reload mid-frame restarts on the next frame.
//
// Ports:
//   clk, reset             : pixel clock, synchronous active-high reset
//   x_pixel, y_pixel, DE   : raw video timing for the current pixel
//   fg_pixel               : camera foreground mask, same cycle as x/y
//   in_polygon             : inside flag, ALIGN_LAT cycles behind its x/y
//   in_polygon_valid       : polygon line table stable
//   judge_start            : one-cycle request, accepted only when idle
//   busy                   : high in every state except IDLE
//   judge_done             : one-cycle verdict strobe
//   judge_pass             : verdict, held until the next accepted judge_start
//   inside_count, outside_count : final counts, held with the verdict
module polygon_fit_judge
   import pip_game_pkg::*;
#(
   parameter int H_ACTIVE  = H_ACTIVE_C,
   parameter int V_ACTIVE  = V_ACTIVE_C,
   parameter int ALIGN_LAT = 1,
   parameter int IN_MIN    = IN_MIN_C,
   parameter int OUT_MAX   = OUT_MAX_C,
   parameter int CNT_W     = 19
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [COORD_W-1:0] x_pixel,
   input  logic [COORD_W-1:0] y_pixel,
   input  logic               DE,
   input  logic               fg_pixel,
   input  logic               in_polygon,
   input  logic               in_polygon_valid,
   input  logic               judge_start,
   output logic               busy,
   output logic               judge_done,
   output logic               judge_pass,
   output logic [CNT_W-1:0]   inside_count,
   output logic [CNT_W-1:0]   outside_count
);

   localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(H_ACTIVE - 1);
   localparam logic [COORD_W-1:0] Y_LAST    = COORD_W'(V_ACTIVE - 1);
   localparam logic [CNT_W-1:0]   IN_MIN_W  = CNT_W'(IN_MIN);
   localparam logic [CNT_W-1:0]   OUT_MAX_W = CNT_W'(OUT_MAX);
   localparam logic [CNT_W-1:0]   CNT_SAT   = '1;
   localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

   // ------------------------------------------------------------------
   // Alignment: everything below looks only at the delayed pixel.
   // ------------------------------------------------------------------
   pix_t pix_raw;
   pix_t pix_d;

   always_comb begin
      pix_raw    = '0;
      pix_raw.de = DE;
      pix_raw.fg = fg_pixel;
      pix_raw.x  = x_pixel;
      pix_raw.y  = y_pixel;
   end

   pixel_align_delay #(
      .DEPTH (ALIGN_LAT)
   ) u_align (
      .clk     (clk),
      .reset   (reset),
      .pix_in  (pix_raw),
      .pix_out (pix_d)
   );

   logic sof_d;
   logic eof_d;
   logic hit_d;
   logic abort;

   assign sof_d = pix_d.de && (pix_d.x == '0) && (pix_d.y == '0);
   assign eof_d = pix_d.de && (pix_d.x == X_LAST) && (pix_d.y == Y_LAST);
   assign hit_d = pix_d.de && pix_d.fg;
   assign abort = !in_polygon_valid;

   // ------------------------------------------------------------------
   // FSM: state register / next state / outputs.
   // ------------------------------------------------------------------
   judge_state_t state;
   judge_state_t state_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:     if (judge_start) state_nxt = WAIT_SOF;
         WAIT_SOF: if (sof_d && in_polygon_valid) state_nxt = ACCUM;
         // Abort is tested first so a reload on the last pixel discards the frame.
         ACCUM: begin
            if (abort) begin
               state_nxt = WAIT_SOF;
            end else if (eof_d) begin
               state_nxt = DECIDE;
            end
         end
         DECIDE:   state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy       = (state != IDLE);
      judge_done = (state == DECIDE);
   end

   // ------------------------------------------------------------------
   // Working counters. The start-of-frame pixel is counted on the same
   // cycle WAIT_SOF recognises it, so it is not lost to the transition.
   // ------------------------------------------------------------------
   logic [CNT_W-1:0] in_cnt;
   logic [CNT_W-1:0] out_cnt;
   logic [CNT_W-1:0] in_cnt_nxt;
   logic [CNT_W-1:0] out_cnt_nxt;
   logic             count_en;

   assign count_en = hit_d && in_polygon_valid &&
                     (((state == WAIT_SOF) && sof_d) || (state == ACCUM));

   // Saturating increment of whichever counter the aligned in_polygon selects.
   always_comb begin
      in_cnt_nxt  = in_cnt;
      out_cnt_nxt = out_cnt;
      if (count_en) begin
         if (in_polygon) begin
            if (in_cnt != CNT_SAT) in_cnt_nxt = in_cnt + CNT_ONE;
         end else begin
            if (out_cnt != CNT_SAT) out_cnt_nxt = out_cnt + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         in_cnt  <= '0;
         out_cnt <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               in_cnt  <= '0;
               out_cnt <= '0;
            end
            WAIT_SOF: begin
               in_cnt  <= in_cnt_nxt;
               out_cnt <= out_cnt_nxt;
            end
            ACCUM: begin
               if (abort) begin
                  in_cnt  <= '0;
                  out_cnt <= '0;
               end else begin
                  in_cnt  <= in_cnt_nxt;
                  out_cnt <= out_cnt_nxt;
               end
            end
            default: begin
               in_cnt  <= in_cnt;
               out_cnt <= out_cnt;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Verdict. Captured from the post-increment values on the way into
   // DECIDE so pass and counts are already valid alongside judge_done.
   // The previous verdict is cleared only when a new request is accepted,
   // which keeps it readable for the whole idle period.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         judge_pass    <= 1'b0;
         inside_count  <= '0;
         outside_count <= '0;
      end else if ((state == IDLE) && judge_start) begin
         judge_pass    <= 1'b0;
         inside_count  <= '0;
         outside_count <= '0;
      end else if ((state == ACCUM) && !abort && eof_d) begin
         judge_pass    <= (in_cnt_nxt >= IN_MIN_W) && (out_cnt_nxt <= OUT_MAX_W);
         inside_count  <= in_cnt_nxt;
         outside_count <= out_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_polygon_fit_judge.sv
module tb_polygon_fit_judge;

   localparam int H_A     = 16;
   localparam int V_A     = 12;
   localparam int H_T     = H_A + 4;
   localparam int V_T     = V_A + 2;
   localparam int L       = 3;
   localparam int IN_MIN  = 40;
   localparam int OUT_MAX = 6;
   localparam int CNT_W   = 8;
   localparam int NJOBS   = 20;

   logic             clk = 1'b0;
   logic             reset;
   logic [9:0]       x_pixel;
   logic [9:0]       y_pixel;
   logic             DE;
   logic             fg_pixel;
   logic             in_polygon;
   logic             in_polygon_valid;
   logic             judge_start;
   logic             busy;
   logic             judge_done;
   logic             judge_pass;
   logic [CNT_W-1:0] inside_count;
   logic [CNT_W-1:0] outside_count;

   polygon_fit_judge #(
      .H_ACTIVE  (H_A),
      .V_ACTIVE  (V_A),
      .ALIGN_LAT (L),
      .IN_MIN    (IN_MIN),
      .OUT_MAX   (OUT_MAX),
      .CNT_W     (CNT_W)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .x_pixel          (x_pixel),
      .y_pixel          (y_pixel),
      .DE               (DE),
      .fg_pixel         (fg_pixel),
      .in_polygon       (in_polygon),
      .in_polygon_valid (in_polygon_valid),
      .judge_start      (judge_start),
      .busy             (busy),
      .judge_done       (judge_done),
      .judge_pass       (judge_pass),
      .inside_count     (inside_count),
      .outside_count    (outside_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int ins;
      int outs;
      bit pass;
      int done_cyc;
   } verdict_t;

   verdict_t exp_q[$];
   int n_checks = 0;
   int n_errors = 0;

   // Last verdict the bench expects the DUT to be holding.
   int last_ins  = 0;
   int last_outs = 0;
   bit last_pass = 0;
   bit hold_chk  = 0;

   // Bench-side model of the upstream point-in-polygon stage latency.
   logic dq [L];

   // Current frame's polygon and foreground description.
   int pxa, pxb, pya, pyb;
   int fxa, fxb, fya, fyb;
   int noise;
   bit directed;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   function automatic bit in_poly(input int x, input int y);
      return (x >= pxa) && (x <= pxb) && (y >= pya) && (y <= pyb);
   endfunction

   function automatic bit fg_active(input int x, input int y);
      if (directed) return (x == 0) && (y == 0);
      if ((x >= fxa) && (x <= fxb) && (y >= fya) && (y <= fyb)) return 1'b1;
      return ($urandom_range(0, noise - 1) == 0);
   endfunction

   task automatic pick_frame(input bit dir);
      int sh;
      directed = dir;
      if (dir) begin
         pxa = 0; pxb = 5; pya = 0; pyb = 5;
         fxa = 0; fxb = 0; fya = 0; fyb = 0; noise = 1;
      end else begin
         pxa   = $urandom_range(0, 4);
         pxb   = $urandom_range(pxa + 6, H_A - 1);
         pya   = $urandom_range(0, 3);
         pyb   = $urandom_range(pya + 4, V_A - 1);
         sh    = $urandom_range(0, 2);
         fxa   = pxa + sh;
         fxb   = pxb + sh;
         fya   = pya + $urandom_range(0, 1);
         fyb   = pyb;
         noise = $urandom_range(20, 60);
      end
   endtask

   // Drives one full frame (active + blanking). When 'judged', the model
   // sums the frame's foreground pixels inside/outside the polygon and
   // queues the verdict due L+1 cycles after the last active pixel.
   task automatic run_frame(input bit judged, input int drop_line,
                            input int st_line, input int st_col,
                            input int bs_line, input int bs_col,
                            input int rst_line);
      int       ins;
      int       outs;
      bit       act;
      bit       fgv;
      bit       pin;
      bit       chk_busy;
      bit       chk_rst;
      verdict_t v;
      ins = 0; outs = 0; chk_busy = 0; chk_rst = 0;
      for (int ly = 0; ly < V_T; ly++) begin
         for (int lx = 0; lx < H_T; lx++) begin
            @(posedge clk);
            #1;
            if (chk_busy) begin
               check("busy_after_start", 32'(busy), 1);
               chk_busy = 0;
            end
            if (chk_rst) begin
               check("reset_busy", 32'(busy), 0);
               check("reset_done", 32'(judge_done), 0);
               check("reset_pass", 32'(judge_pass), 0);
               check("reset_inside", 32'(inside_count), 0);
               check("reset_outside", 32'(outside_count), 0);
               chk_rst = 0;
            end
            act = (lx < H_A) && (ly < V_A);
            fgv = act ? fg_active(lx, ly) : (directed ? 1'b1 : 1'($urandom_range(0, 1)));
            pin = in_poly(lx, ly);
            x_pixel  = 10'(lx);
            y_pixel  = 10'(ly);
            DE       = act;
            fg_pixel = fgv;
            in_polygon = dq[L-1];
            for (int i = L - 1; i > 0; i--) dq[i] = dq[i-1];
            dq[0] = pin;
            in_polygon_valid = (ly != drop_line);
            judge_start = ((ly == st_line) && (lx == st_col)) ||
                          ((ly == bs_line) && (lx == bs_col));
            reset = (ly == rst_line) && (lx == 2);
            if ((ly == st_line) && (lx == st_col)) chk_busy = 1;
            if (reset) chk_rst = 1;
            if (judged && act && fgv) begin
               if (pin) ins++;
               else     outs++;
            end
            if (judged && (lx == H_A - 1) && (ly == V_A - 1)) begin
               v.ins      = ins;
               v.outs     = outs;
               v.pass     = (ins >= IN_MIN) && (outs <= OUT_MAX);
               v.done_cyc = cyc + L + 1;
               exp_q.push_back(v);
            end
         end
      end
   endtask

   task automatic check_held();
      check("held_pass", 32'(judge_pass), 32'(last_pass));
      check("held_inside", 32'(inside_count), 32'(last_ins));
      check("held_outside", 32'(outside_count), 32'(last_outs));
   endtask

   // Monitor: every judge_done pops the oldest expected verdict.
   initial begin
      verdict_t e;
      forever begin
         @(negedge clk);
         if (hold_chk) begin
            check("idle_after_done", 32'(busy), 0);
            check("stable_pass", 32'(judge_pass), 32'(last_pass));
            check("stable_inside", 32'(inside_count), 32'(last_ins));
            check("stable_outside", 32'(outside_count), 32'(last_outs));
            hold_chk = 0;
         end
         if (!reset && judge_done) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_done: judge_done at cycle %0d, required no verdict", cyc);
            end else begin
               e = exp_q.pop_front();
               check("done_cycle", 32'(cyc), 32'(e.done_cyc));
               check("inside_count", 32'(inside_count), 32'(e.ins));
               check("outside_count", 32'(outside_count), 32'(e.outs));
               check("judge_pass", 32'(judge_pass), 32'(e.pass));
               last_ins  = e.ins;
               last_outs = e.outs;
               last_pass = e.pass;
               hold_chk  = 1;
            end
         end
      end
   end

   initial begin
      int sl, sc, nab, dl, bl, bc;
      for (int i = 0; i < L; i++) dq[i] = 1'b0;
      reset = 1'b1; DE = 1'b0; fg_pixel = 1'b0; x_pixel = '0; y_pixel = '0;
      in_polygon = 1'b0; in_polygon_valid = 1'b1; judge_start = 1'b0;
      directed = 0;
      repeat (3) @(posedge clk);
      #1;
      check("por_busy", 32'(busy), 0);
      check("por_done", 32'(judge_done), 0);
      check("por_pass", 32'(judge_pass), 0);
      check("por_inside", 32'(inside_count), 0);
      check("por_outside", 32'(outside_count), 0);
      reset = 1'b0;

      for (int j = 0; j < NJOBS; j++) begin
         check_held();
         pick_frame(0);
         sl = $urandom_range(1, V_T - 1);
         sc = $urandom_range(0, H_T - 2);
         run_frame(0, -1, sl, sc, -1, -1, -1);
         nab = (j == 0) ? 0 : ((j == 1) ? 1 : $urandom_range(0, 2));
         for (int a = 0; a < nab; a++) begin
            pick_frame(0);
            dl = $urandom_range(1, V_A - 2);
            run_frame(0, dl, -1, -1, -1, -1, -1);
         end
         pick_frame(j == 0);
         if ((j == 1) || ($urandom_range(0, 1) == 1)) begin
            bl = $urandom_range(0, V_A - 1);
            bc = $urandom_range(0, H_T - 1);
         end else begin
            bl = -1;
            bc = -1;
         end
         run_frame(1, -1, -1, -1, bl, bc, -1);
      end

      // Reset in the middle of an accumulating frame: no verdict may follow.
      check_held();
      pick_frame(0);
      run_frame(0, -1, 3, 4, -1, -1, -1);
      pick_frame(0);
      run_frame(0, -1, -1, -1, -1, -1, 5);
      pick_frame(0);
      run_frame(0, -1, -1, -1, -1, -1, -1);

      repeat (4) @(posedge clk);
      #1;
      check("pending_verdicts", 32'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
